// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the load/store memory access unit: funct3 encodings,
// FSM states and the access legality check.
package memory_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_WRITE = 2'd2
    } state_t;

    // Unsigned variants exist only for loads; alignment follows the access size.
    function automatic logic access_fault(input logic [2:0] funct3,
                                          input logic       write,
                                          input logic [1:0] offset);
        logic fault;
        case (funct3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = offset[0];
            F3_W:    fault = (offset != 2'b00);
            F3_BU:   fault = write;
            F3_HU:   fault = write | offset[0];
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Request/response channel and memory port bundle of the memory access unit.
interface memory_access_unit_if #(
    parameter int ADDRESS_SIZE = 10
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [2:0]              req_funct3;
    logic [ADDRESS_SIZE+1:0] req_address;
    logic [31:0]             req_write_data;
    logic                    resp_valid;
    logic [31:0]             resp_read_data;
    logic                    resp_fault;
    logic                    mem_read_enable;
    logic [ADDRESS_SIZE-1:0] mem_read_address;
    logic                    mem_write_enable;
    logic [ADDRESS_SIZE-1:0] mem_write_address;
    logic [31:0]             mem_write_data;
    logic [31:0]             mem_read_data;

    modport slave (
        input  req_valid, req_write, req_funct3, req_address, req_write_data, mem_read_data,
        output req_ready, resp_valid, resp_read_data, resp_fault,
               mem_read_enable, mem_read_address, mem_write_enable, mem_write_address, mem_write_data
    );

    modport master (
        output req_valid, req_write, req_funct3, req_address, req_write_data, mem_read_data,
        input  req_ready, resp_valid, resp_read_data, resp_fault,
               mem_read_enable, mem_read_address, mem_write_enable, mem_write_address, mem_write_data
    );
endinterface

// File: rtl/memory_access_unit_byte_lane_merge.sv
// Replaces one byte or halfword lane of a little-endian word with new store data.
module byte_lane_merge (
    input  logic [31:0] old_word,
    input  logic [15:0] new_data,
    input  logic [1:0]  offset,
    input  logic        half,
    output logic [31:0] merged
);
    always_comb begin
        merged = old_word;
        if (half) begin
            if (offset[1]) merged[31:16] = new_data;
            else           merged[15:0]  = new_data;
        end else begin
            case (offset)
                2'd0:    merged[7:0]   = new_data[7:0];
                2'd1:    merged[15:8]  = new_data[7:0];
                2'd2:    merged[23:16] = new_data[7:0];
                default: merged[31:24] = new_data[7:0];
            endcase
        end
    end
endmodule

// File: rtl/memory_access_unit.sv
// RV32I load/store controller for a word-addressed block memory with a
// one-cycle registered read; sub-word stores use read-modify-write.
module memory_access_unit
    import memory_access_pkg::*;
#(
    parameter int ADDRESS_SIZE = 10,
    parameter int WORD_SIZE    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    memory_access_unit_if.slave bus
);
    state_t                  state;
    logic [ADDRESS_SIZE-1:0] lat_addr;
    logic [1:0]              lat_offset;
    logic [2:0]              lat_funct3;
    logic [15:0]             lat_data;

    logic                    accept;
    logic                    fault;
    logic [ADDRESS_SIZE-1:0] word_addr;
    logic [1:0]              offset;
    logic [31:0]             merged;
    logic [7:0]              lane_byte;
    logic [15:0]             lane_half;
    logic [WORD_SIZE-1:0]    load_result;

    assign word_addr     = bus.req_address[ADDRESS_SIZE+1:2];
    assign offset        = bus.req_address[1:0];
    assign bus.req_ready = rst_n && (state == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign fault         = access_fault(bus.req_funct3, bus.req_write, offset);

    byte_lane_merge u_merge (
        .old_word (bus.mem_read_data),
        .new_data (lat_data),
        .offset   (lat_offset),
        .half     (lat_funct3 == F3_H),
        .merged   (merged)
    );

    // Memory strobes are combinational so the read lands in the accept cycle.
    always_comb begin
        bus.mem_read_enable   = 1'b0;
        bus.mem_read_address  = word_addr;
        bus.mem_write_enable  = 1'b0;
        bus.mem_write_address = word_addr;
        bus.mem_write_data    = bus.req_write_data;
        if (state == RMW_WRITE) begin
            bus.mem_write_enable  = rst_n;
            bus.mem_write_address = lat_addr;
            bus.mem_write_data    = merged;
        end else if (accept && !fault) begin
            if (bus.req_write && (bus.req_funct3 == F3_W)) bus.mem_write_enable = 1'b1;
            else                                            bus.mem_read_enable  = 1'b1;
        end
    end

    assign lane_byte = bus.mem_read_data[{lat_offset, 3'b000} +: 8];
    assign lane_half = lat_offset[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

    always_comb begin
        case (lat_funct3)
            F3_B:    load_result = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_result = {24'h0, lane_byte};
            F3_H:    load_result = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_result = {16'h0, lane_half};
            default: load_result = bus.mem_read_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            lat_addr           <= '0;
            lat_offset         <= '0;
            lat_funct3         <= '0;
            lat_data           <= '0;
            bus.resp_valid     <= 1'b0;
            bus.resp_fault     <= 1'b0;
            bus.resp_read_data <= '0;
        end else begin
            bus.resp_valid     <= 1'b0;
            bus.resp_fault     <= 1'b0;
            bus.resp_read_data <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_addr   <= word_addr;
                        lat_offset <= offset;
                        lat_funct3 <= bus.req_funct3;
                        lat_data   <= bus.req_write_data[15:0];
                        if (fault) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_fault <= 1'b1;
                        end else if (!bus.req_write) begin
                            state <= LOAD_WAIT;
                        end else if (bus.req_funct3 == F3_W) begin
                            bus.resp_valid <= 1'b1;
                        end else begin
                            state <= RMW_WRITE;
                        end
                    end
                end
                LOAD_WAIT: begin
                    bus.resp_valid     <= 1'b1;
                    bus.resp_read_data <= load_result;
                    state              <= IDLE;
                end
                RMW_WRITE: begin
                    bus.resp_valid <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
